// File: rtl/brlite_local_if_pkg.sv
// ---------------------------------------------------------------------------
// brlite_local_if_pkg
//   Shared types and constants for the BrLite per-PE network interface.
//   - br_data_t         : flit payload carried on the broadcast mesh
//   - br_if_tx_state_t  : injection FSM states
//   - BR_IF_TIMEOUT_DEFAULT : default injection-timeout threshold (cycles)
// ---------------------------------------------------------------------------
package brlite_local_if_pkg;

    localparam int unsigned BR_DATA_W = 32;

    typedef logic [BR_DATA_W-1:0] br_data_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_GAP
    } br_if_tx_state_t;

    localparam int unsigned BR_IF_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/brlite_fifo.sv
// ---------------------------------------------------------------------------
// brlite_fifo
//   Synchronous single-clock FIFO of br_data_t, asynchronous active-high reset.
//   Ports:
//     clk_i, rst_i   clock / async reset
//     push_i, data_i write request and data (ignored when full)
//     pop_i          read request (ignored when empty)
//     full_o, empty_o occupancy flags
//     head_o         oldest entry (valid while !empty_o)
//     count_o        number of stored entries
// ---------------------------------------------------------------------------
module brlite_fifo
    import brlite_local_if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  br_data_t                 data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output br_data_t                 head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    br_data_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/brlite_local_if.sv
// ---------------------------------------------------------------------------
// brlite_local_if
//   Per-PE network interface between a PE and the LOCAL port of its BrLite
//   router. TX: PE flits are buffered and injected with req/ack, gated by the
//   router's local busy flag. RX: router flits are captured, acked for one
//   cycle and buffered for the PE.
//   Ports:
//     clk_i, rst_i                          clock / async active-high reset
//     pe_tx_data_i/valid_i, pe_tx_ready_o   PE -> TX FIFO (valid/ready)
//     pe_rx_data_o/valid_o, pe_rx_ready_i   RX FIFO -> PE (valid/ready)
//     noc_flit_o, noc_req_o, noc_ack_i      injection into router local input
//     noc_flit_i, noc_req_i, noc_ack_o      delivery from router local output
//     noc_busy_i                            router local busy
//     clr_timeout_i, tx_timeout_o           sticky injection-timeout flag
//     tx_cnt_o, rx_cnt_o                    wrapping flit counters
// ---------------------------------------------------------------------------
module brlite_local_if
    import brlite_local_if_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned TIMEOUT  = BR_IF_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  br_data_t    pe_tx_data_i,
    input  logic        pe_tx_valid_i,
    output logic        pe_tx_ready_o,
    output br_data_t    pe_rx_data_o,
    output logic        pe_rx_valid_o,
    input  logic        pe_rx_ready_i,
    output br_data_t    noc_flit_o,
    output logic        noc_req_o,
    input  logic        noc_ack_i,
    input  br_data_t    noc_flit_i,
    input  logic        noc_req_i,
    output logic        noc_ack_o,
    input  logic        noc_busy_i,
    input  logic        clr_timeout_i,
    output logic        tx_timeout_o,
    output logic [31:0] tx_cnt_o,
    output logic [31:0] rx_cnt_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    br_data_t                  tx_head;
    br_data_t                  rx_head;
    logic                      tx_full, tx_empty;
    logic                      rx_full, rx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic                      unused_counts;

    br_if_tx_state_t state_q;
    logic            noc_req_q;
    br_data_t        noc_flit_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic            tx_timeout_q;
    logic [31:0]     tx_cnt_q;
    logic            noc_ack_q;
    logic [31:0]     rx_cnt_q;

    logic tx_push, tx_pop, rx_capture, rx_pop, tmo_hit;

    assign unused_counts = ^{tx_count, rx_count};

    assign tx_push    = pe_tx_valid_i && !tx_full;
    assign tx_pop     = (state_q == TX_REQ) && noc_ack_i;
    // No capture during our own ack cycle: the router still holds req then.
    assign rx_capture = noc_req_i && !rx_full && !noc_ack_q;
    assign rx_pop     = pe_rx_ready_i && !rx_empty;
    // Fires once, on the REQ cycle that brings the counter up to TIMEOUT.
    assign tmo_hit    = (state_q == TX_REQ) && !noc_ack_i &&
                        (tmo_cnt_q == TMO_MAX - 1'b1);

    brlite_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push),
        .data_i  (pe_tx_data_i),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head),
        .count_o (tx_count)
    );

    brlite_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_capture),
        .data_i  (noc_flit_i),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head),
        .count_o (rx_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= TX_IDLE;
            noc_req_q    <= 1'b0;
            noc_flit_q   <= '0;
            tmo_cnt_q    <= '0;
            tx_timeout_q <= 1'b0;
            tx_cnt_q     <= '0;
        end else begin
            if (clr_timeout_i)
                tx_timeout_q <= 1'b0;
            else if (tmo_hit)
                tx_timeout_q <= 1'b1;

            unique case (state_q)
                TX_IDLE: begin
                    if (!tx_empty && !noc_busy_i) begin
                        state_q    <= TX_REQ;
                        noc_req_q  <= 1'b1;
                        noc_flit_q <= tx_head;
                        tmo_cnt_q  <= '0;
                    end
                end
                TX_REQ: begin
                    if (noc_ack_i) begin
                        state_q   <= TX_GAP;
                        noc_req_q <= 1'b0;
                        tx_cnt_q  <= tx_cnt_q + 32'd1;
                    end else if (tmo_cnt_q != TMO_MAX) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                TX_GAP: begin
                    state_q <= TX_IDLE;
                end
                default: begin
                    state_q   <= TX_IDLE;
                    noc_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            noc_ack_q <= 1'b0;
            rx_cnt_q  <= '0;
        end else begin
            noc_ack_q <= rx_capture;
            if (rx_capture) rx_cnt_q <= rx_cnt_q + 32'd1;
        end
    end

    assign pe_tx_ready_o = !tx_full;
    assign pe_rx_valid_o = !rx_empty;
    assign pe_rx_data_o  = rx_head;
    assign noc_req_o     = noc_req_q;
    assign noc_flit_o    = noc_flit_q;
    assign noc_ack_o     = noc_ack_q;
    assign tx_timeout_o  = tx_timeout_q;
    assign tx_cnt_o      = tx_cnt_q;
    assign rx_cnt_o      = rx_cnt_q;

endmodule
